// File: rtl/atm_pkg.sv
// Shared constants for the ATM account-record interface: opcodes, response
// status codes, record layout and default debit rules.
package atm_pkg;

  localparam int REC_W = 40;

  // Record layout {acct[15:0], pin[7:0], balance[15:0]}
  localparam int ACCT_HI = 39;
  localparam int PIN_HI  = 23;
  localparam int BAL_HI  = 15;

  localparam logic [1:0] OP_VERIFY = 2'b00;
  localparam logic [1:0] OP_DEBIT  = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_NO_ACCT   = 3'd1;
  localparam logic [2:0] ST_BAD_PIN   = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_AMT_LIMIT = 3'd4;
  localparam logic [2:0] ST_INSUFF    = 3'd5;
  localparam logic [2:0] ST_BAD_IDX   = 3'd6;
  localparam logic [2:0] ST_BAD_OP    = 3'd7;

  localparam logic [15:0] MIN_BAL_DEF = 16'h0500;
  localparam logic [15:0] MAX_WD_DEF  = 16'h4000;

endpackage

// File: rtl/account_ledger_if.sv
// Request/response channel between the ATM session controller (master)
// and the account ledger (slave).
interface account_ledger_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_acct;
  logic [7:0]  req_pin;
  logic [15:0] req_amt;
  logic [3:0]  req_idx;
  logic [39:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic [3:0]  rsp_idx;

  modport master (
    output req_valid, req_op, req_acct, req_pin, req_amt, req_idx, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_idx
  );

  modport slave (
    input  req_valid, req_op, req_acct, req_pin, req_amt, req_idx, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_idx
  );
endinterface

// File: rtl/ledger_mem.sv
// Account record store: record array (not reset), per-slot valid bits and
// PIN-failure counters (reset). One combinational read port, one write port.
module ledger_mem import atm_pkg::*; #(
  parameter int NUM_REC = 10,
  parameter int IDX_W   = 4,
  parameter int FAIL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [REC_W-1:0]  rd_rec,
  output logic              rd_valid,
  output logic [FAIL_W-1:0] rd_fail,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [REC_W-1:0]  wr_rec,
  input  logic [FAIL_W-1:0] wr_fail
);

  logic [REC_W-1:0]               rec [NUM_REC];
  logic [NUM_REC-1:0]             vld;
  logic [NUM_REC-1:0][FAIL_W-1:0] fail;

  assign rd_rec   = rec[rd_idx];
  assign rd_valid = vld[rd_idx];
  assign rd_fail  = fail[rd_idx];

  // Record contents survive reset; only written by the ledger's EXEC step
  always_ff @(posedge clk) begin
    if (wr_en) rec[wr_idx] <= wr_rec;
  end

  // Any write leaves the slot valid and installs the new failure count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= '0;
      fail <= '0;
    end else if (wr_en) begin
      vld[wr_idx]  <= 1'b1;
      fail[wr_idx] <= wr_fail;
    end
  end

endmodule

// File: rtl/account_ledger.sv
// Account ledger: accepts VERIFY/DEBIT/WRITE requests, searches the record
// store one slot per cycle and applies lockout, PIN and debit rules.
module account_ledger import atm_pkg::*; #(
  parameter int          NUM_REC  = 10,
  parameter logic [15:0] MIN_BAL  = MIN_BAL_DEF,
  parameter logic [15:0] MAX_WD   = MAX_WD_DEF,
  parameter int          MAX_FAIL = 3
) (
  input logic             clk,
  input logic             rst,
  account_ledger_if.slave bus
);

  localparam int IDX_W  = 4;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REC - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [1:0]       op_q;
  logic [15:0]      acct_q, amt_q;
  logic [7:0]       pin_q;
  logic [IDX_W-1:0] idx_q;
  logic [REC_W-1:0] data_q;
  logic [2:0]       rsp_status_q;
  logic [15:0]      rsp_balance_q;
  logic [IDX_W-1:0] rsp_idx_q;

  logic [REC_W-1:0]  rd_rec, ex_rec;
  logic              rd_valid, hit, ex_we;
  logic [FAIL_W-1:0] rd_fail, ex_fail;
  logic [2:0]        ex_status;
  logic [15:0]       ex_bal;
  logic [IDX_W-1:0]  ex_idx, wr_idx;

  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] f);
    return (f == FAIL_MAX) ? f : f + FAIL_W'(1);
  endfunction

  // 17-bit difference so an amount above the balance can never wrap into range
  function automatic logic debit_ok(input logic [15:0] bal, input logic [15:0] amt);
    logic [16:0] diff;
    diff = {1'b0, bal} - {1'b0, amt};
    return !diff[16] && (diff[15:0] >= MIN_BAL);
  endfunction

  ledger_mem #(.NUM_REC(NUM_REC), .IDX_W(IDX_W), .FAIL_W(FAIL_W)) u_mem (
    .clk(clk), .rst(rst),
    .rd_idx(ptr), .rd_rec(rd_rec), .rd_valid(rd_valid), .rd_fail(rd_fail),
    .wr_en(state == S_EXEC && ex_we), .wr_idx(wr_idx), .wr_rec(ex_rec), .wr_fail(ex_fail)
  );

  assign hit    = rd_valid && (rd_rec[ACCT_HI:PIN_HI+1] == acct_q);
  assign wr_idx = (op_q == OP_WRITE) ? idx_q : ptr;

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_balance = rsp_balance_q;
  assign bus.rsp_idx     = rsp_idx_q;

  // Rule evaluation for the EXEC cycle; ptr still addresses the matched slot
  always_comb begin
    ex_status = ST_OK;
    ex_bal    = '0;
    ex_idx    = ptr;
    ex_we     = 1'b0;
    ex_rec    = rd_rec;
    ex_fail   = rd_fail;
    if (op_q == OP_WRITE) begin
      if (idx_q > LAST_IDX) begin
        ex_status = ST_BAD_IDX;
        ex_idx    = '0;
      end else begin
        ex_we   = 1'b1;
        ex_rec  = data_q;
        ex_fail = '0;
        ex_bal  = data_q[BAL_HI:0];
        ex_idx  = idx_q;
      end
    end else begin
      ex_we = 1'b1;
      if (rd_fail == FAIL_MAX) begin
        ex_status = ST_LOCKED;
      end else if (rd_rec[PIN_HI:BAL_HI+1] != pin_q) begin
        ex_status = ST_BAD_PIN;
        ex_fail   = fail_inc(rd_fail);
      end else begin
        ex_fail = '0;
        ex_bal  = rd_rec[BAL_HI:0];
        if (op_q == OP_DEBIT) begin
          if (amt_q > MAX_WD) begin
            ex_status = ST_AMT_LIMIT;
          end else if (!debit_ok(rd_rec[BAL_HI:0], amt_q)) begin
            ex_status = ST_INSUFF;
          end else begin
            ex_bal            = rd_rec[BAL_HI:0] - amt_q;
            ex_rec[BAL_HI:0]  = ex_bal;
          end
        end
      end
    end
  end

  // Request fields are captured at acceptance
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.req_valid) begin
      op_q   <= bus.req_op;
      acct_q <= bus.req_acct;
      pin_q  <= bus.req_pin;
      amt_q  <= bus.req_amt;
      idx_q  <= bus.req_idx;
      data_q <= bus.req_data;
    end
  end

  // Control FSM plus registered response fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      rsp_status_q  <= '0;
      rsp_balance_q <= '0;
      rsp_idx_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          ptr <= '0;
          case (bus.req_op)
            OP_VERIFY, OP_DEBIT: state <= S_SEARCH;
            OP_WRITE:            state <= S_EXEC;
            default: begin
              state         <= S_RESP;
              rsp_status_q  <= ST_BAD_OP;
              rsp_balance_q <= '0;
              rsp_idx_q     <= '0;
            end
          endcase
        end
        S_SEARCH: begin
          if (hit) begin
            state <= S_EXEC;
          end else if (ptr == LAST_IDX) begin
            state         <= S_RESP;
            rsp_status_q  <= ST_NO_ACCT;
            rsp_balance_q <= '0;
            rsp_idx_q     <= '0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        S_EXEC: begin
          state         <= S_RESP;
          rsp_status_q  <= ex_status;
          rsp_balance_q <= ex_bal;
          rsp_idx_q     <= ex_idx;
        end
        default: if (bus.rsp_ready) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_account_ledger.sv
// Directed bench for account_ledger: table of sequential requests with
// hand-computed responses and latencies, plus back-pressure and reset cases.
module tb_account_ledger;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  account_ledger_if bus();
  account_ledger dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] acct;
    logic [7:0]  pin;
    logic [15:0] amt;
    logic [3:0]  idx;
    logic [39:0] data;
    logic [2:0]  st;
    logic [15:0] bal;
    logic [3:0]  ridx;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] acct, input logic [7:0] pin,
                              input logic [15:0] amt, input logic [3:0] idx, input logic [39:0] data,
                              input logic [2:0] st, input logic [15:0] bal, input logic [3:0] ridx,
                              input int lat);
    vec_t v;
    v.op = op; v.acct = acct; v.pin = pin; v.amt = amt; v.idx = idx; v.data = data;
    v.st = st; v.bal = bal; v.ridx = ridx; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, complete it.
  task automatic do_req(input vec_t v, output logic [2:0] st, output logic [15:0] bal,
                        output logic [3:0] idx, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = v.op; bus.req_acct = v.acct; bus.req_pin = v.pin;
    bus.req_amt = v.amt; bus.req_idx = v.idx; bus.req_data = v.data;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1; st = 'x; bal = 'x; idx = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = c; st = bus.rsp_status; bal = bus.rsp_balance; idx = bus.rsp_idx;
        break;
      end
    end
    if (lat > 0) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [2:0] st; logic [15:0] bal; logic [3:0] idx; int lat;
    do_req(v, st, bal, idx, lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " status"}, 64'(st), 64'(v.st));
    check({tag, " balance"}, 64'(bal), 64'(v.bal));
    check({tag, " idx"}, 64'(idx), 64'(v.ridx));
  endtask

  initial begin
    logic [2:0] hs; logic [15:0] hb; logic [3:0] hi;
    int n;

    vt[0]  = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd2, {16'h1234, 8'hA5, 16'h2000}, ST_OK, 16'h2000, 4'd2, 2);
    vt[1]  = mk(OP_VERIFY, 16'h1234, 8'hA5, 16'h0000, 4'd0, '0, ST_OK,        16'h2000, 4'd2, 5);
    vt[2]  = mk(OP_DEBIT,  16'h1234, 8'hA5, 16'h1000, 4'd0, '0, ST_OK,        16'h1000, 4'd2, 5);
    vt[3]  = mk(OP_DEBIT,  16'h1234, 8'hA5, 16'h0C00, 4'd0, '0, ST_INSUFF,    16'h1000, 4'd2, 5);
    vt[4]  = mk(OP_DEBIT,  16'h1234, 8'hA5, 16'h4001, 4'd0, '0, ST_AMT_LIMIT, 16'h1000, 4'd2, 5);
    vt[5]  = mk(OP_VERIFY, 16'h1234, 8'h00, 16'h0000, 4'd0, '0, ST_BAD_PIN,   16'h0000, 4'd2, 5);
    vt[6]  = mk(OP_VERIFY, 16'h1234, 8'h00, 16'h0000, 4'd0, '0, ST_BAD_PIN,   16'h0000, 4'd2, 5);
    vt[7]  = mk(OP_VERIFY, 16'h1234, 8'h00, 16'h0000, 4'd0, '0, ST_BAD_PIN,   16'h0000, 4'd2, 5);
    vt[8]  = mk(OP_VERIFY, 16'h1234, 8'hA5, 16'h0000, 4'd0, '0, ST_LOCKED,    16'h0000, 4'd2, 5);
    vt[9]  = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd2, {16'h1234, 8'hA5, 16'h2000}, ST_OK, 16'h2000, 4'd2, 2);
    vt[10] = mk(OP_VERIFY, 16'h1234, 8'hA5, 16'h0000, 4'd0, '0, ST_OK,        16'h2000, 4'd2, 5);
    vt[11] = mk(OP_VERIFY, 16'hFFFF, 8'hA5, 16'h0000, 4'd0, '0, ST_NO_ACCT,   16'h0000, 4'd0, 11);
    vt[12] = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd10, {16'hAAAA, 8'h11, 16'h1111}, ST_BAD_IDX, 16'h0000, 4'd0, 2);
    vt[13] = mk(OP_RSVD,   16'h1234, 8'hA5, 16'h0000, 4'd0, '0, ST_BAD_OP,    16'h0000, 4'd0, 1);
    // Duplicate account in a lower slot takes precedence
    vt[14] = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd0, {16'h1234, 8'h11, 16'h0800}, ST_OK, 16'h0800, 4'd0, 2);
    vt[15] = mk(OP_VERIFY, 16'h1234, 8'hA5, 16'h0000, 4'd0, '0, ST_BAD_PIN,   16'h0000, 4'd0, 3);
    vt[16] = mk(OP_VERIFY, 16'h1234, 8'h11, 16'h0000, 4'd0, '0, ST_OK,        16'h0800, 4'd0, 3);
    // Debit leaving exactly MIN_BAL, then one more unit, then amount above balance
    vt[17] = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd5, {16'hBEEF, 8'h42, 16'h0900}, ST_OK, 16'h0900, 4'd5, 2);
    vt[18] = mk(OP_DEBIT,  16'hBEEF, 8'h42, 16'h0400, 4'd0, '0, ST_OK,        16'h0500, 4'd5, 8);
    vt[19] = mk(OP_DEBIT,  16'hBEEF, 8'h42, 16'h0001, 4'd0, '0, ST_INSUFF,    16'h0500, 4'd5, 8);
    vt[20] = mk(OP_DEBIT,  16'hBEEF, 8'h42, 16'h0600, 4'd0, '0, ST_INSUFF,    16'h0500, 4'd5, 8);
    // Withdrawal exactly at MAX_WD is allowed
    vt[21] = mk(OP_WRITE,  16'h0000, 8'h00, 16'h0000, 4'd7, {16'hCAFE, 8'h77, 16'h9000}, ST_OK, 16'h9000, 4'd7, 2);
    vt[22] = mk(OP_DEBIT,  16'hCAFE, 8'h77, 16'h4000, 4'd0, '0, ST_OK,        16'h5000, 4'd7, 10);

    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req_op = '0; bus.req_acct = '0; bus.req_pin = '0;
    bus.req_amt = '0; bus.req_idx = '0; bus.req_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset rsp_status", 64'(bus.rsp_status), 64'd0);
    check("reset rsp_balance", 64'(bus.rsp_balance), 64'd0);
    check("reset rsp_idx", 64'(bus.rsp_idx), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Back-pressure: response held stable, no new request accepted
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_VERIFY; bus.req_acct = 16'hBEEF; bus.req_pin = 8'h42;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 40);
    check("hold first response", {bus.rsp_valid, bus.rsp_status, bus.rsp_balance, bus.rsp_idx},
          {1'b1, ST_OK, 16'h0500, 4'd5});
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold cycle %0d", c),
            {bus.rsp_valid, bus.req_ready, bus.rsp_status, bus.rsp_balance, bus.rsp_idx},
            {1'b1, 1'b0, ST_OK, 16'h0500, 4'd5});
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("hold released", {bus.rsp_valid, bus.req_ready}, {1'b0, 1'b1});

    // Reset during the search of a DEBIT on slot 7 (balance 5000)
    bus.req_valid = 1'b1; bus.req_op = OP_DEBIT; bus.req_acct = 16'hCAFE;
    bus.req_pin = 8'h77; bus.req_amt = 16'h1000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-search reset outputs",
          {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_balance, bus.rsp_idx},
          {1'b1, 1'b0, 3'd0, 16'h0000, 4'd0});
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) @(negedge clk);
    check("record kept across reset", 64'(dut.u_mem.rec[7][15:0]), 64'h5000);
    run_vec("after reset lookup",
            mk(OP_VERIFY, 16'hCAFE, 8'h77, 16'h0, 4'd0, '0, ST_NO_ACCT, 16'h0, 4'd0, 11));
    run_vec("after reset reload",
            mk(OP_WRITE, 16'h0, 8'h0, 16'h0, 4'd7, {16'hCAFE, 8'h77, 16'h5000}, ST_OK, 16'h5000, 4'd7, 2));
    run_vec("after reset verify",
            mk(OP_VERIFY, 16'hCAFE, 8'h77, 16'h0, 4'd0, '0, ST_OK, 16'h5000, 4'd7, 10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/account_ledger.md
Name: account_ledger

Overview:
- Responder side of the ATM account-record interface: owns the account record store and answers requests from the ATM session controller.
- Supported requests: PIN verify / balance enquiry, debit (withdrawal), record load.
- Record format: 40 bits, {acct[15:0], pin[7:0], balance[15:0]}.
- Finds the record by a sequential search, one entry per cycle, and enforces the withdrawal limit, minimum balance and PIN-retry lockout.

Parameters:
- NUM_REC, 10: number of record slots; index width is 4 bits.
- MIN_BAL, 16'h0500: minimum balance that must remain after a debit.
- MAX_WD, 16'h4000: largest permitted single withdrawal.
- MAX_FAIL, 3: consecutive PIN failures that lock a record.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  ledger can accept a request
- req_op  in  2  00 VERIFY, 01 DEBIT, 10 WRITE, 11 reserved
- req_acct  in  16  account number (VERIFY/DEBIT)
- req_pin  in  8  PIN (VERIFY/DEBIT)
- req_amt  in  16  debit amount
- req_idx  in  4  slot index (WRITE)
- req_data  in  40  record to load (WRITE)
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_status  out  3  0 OK, 1 NO_ACCT, 2 BAD_PIN, 3 LOCKED, 4 AMT_LIMIT, 5 INSUFF, 6 BAD_IDX, 7 BAD_OP
- rsp_balance  out  16  record balance after the operation (0 unless status OK, INSUFF or AMT_LIMIT)
- rsp_idx  out  4  slot index of the matched or written record (0 on NO_ACCT, BAD_OP, BAD_IDX)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_status=0; rsp_balance=0; rsp_idx=0.
  - All per-slot valid bits and fail counters cleared.
  - Record contents are not reset.
- FSM states: IDLE, SEARCH, EXEC, RESP.
- Handshake:
  - req_ready=1 only in IDLE. A request is accepted when req_valid&&req_ready; all req_* fields are captured into internal registers at acceptance.
  - rsp_* fields are registered and stable while rsp_valid=1. The response completes on rsp_valid&&rsp_ready, then the FSM returns to IDLE.
  - No new request is accepted in the cycle the response completes.
- Transitions out of IDLE on acceptance:
  - VERIFY/DEBIT go to SEARCH with the pointer at 0.
  - WRITE goes directly to EXEC.
  - Reserved op goes directly to RESP with BAD_OP.
- SEARCH:
  - Each cycle, examine slot ptr; a hit is valid[ptr] && acct==req_acct.
  - On hit, go to EXEC. The lowest-index hit wins when account numbers are duplicated.
  - If ptr==NUM_REC-1 with no hit, go to RESP with NO_ACCT.
- Latency: a hit at slot k with the request accepted at cycle 0 gives rsp_valid=1 at cycle k+3. WRITE gives rsp_valid=1 at cycle 2.
- EXEC on the matched slot, checks applied in this priority order:
  - fail==MAX_FAIL: LOCKED; the PIN is not compared.
  - PIN mismatch: BAD_PIN; fail counter increments, saturating at MAX_FAIL.
  - VERIFY with PIN match: OK; fail counter cleared.
  - DEBIT with PIN match: fail counter cleared, then:
    - req_amt > MAX_WD: AMT_LIMIT.
    - req_amt > balance, or balance-req_amt < MIN_BAL: INSUFF. Compare in 17 bits; no wrap-around.
    - Otherwise: balance <= balance-req_amt; OK.
  - rsp_balance is the post-operation balance.
- WRITE:
  - req_idx >= NUM_REC: BAD_IDX; no state change.
  - Otherwise: slot <= req_data; valid=1; fail=0; status OK; rsp_balance=req_data[15:0].
- Memory updates happen only in the EXEC cycle. A reset asserted before EXEC leaves the records unchanged. Reset during RESP drops rsp_valid immediately.
- Back-to-back requests: a request issued after a completed DEBIT/WRITE sees the updated record.

Decomposition:
- Package atm_pkg holds:
  - opcode constants;
  - status code constants;
  - record field slices (ACCT_HI=39, PIN_HI=23, BAL_HI=15);
  - MIN_BAL and MAX_WD defaults.
- One sub-module, ledger_mem: NUM_REC x 40 record array plus valid and fail-counter arrays. It has one combinational read port (ptr) and one write port used in EXEC. The FSM and rule checks stay in account_ledger.

Test Plan:
- WRITE idx 2 data {16'h1234, 8'hA5, 16'h2000}, then VERIFY acct 1234 pin A5 -> status OK, balance 2000, idx 2; response at cycle 5 after acceptance.
- DEBIT 1234/A5 amt 1000 -> OK, balance 1000. Repeat DEBIT amt 0C00 -> INSUFF, balance 1000 unchanged. DEBIT amt 4001 -> AMT_LIMIT.
- VERIFY 1234 with pin 00 three times -> BAD_PIN x3. A fourth request with the correct pin A5 -> LOCKED. WRITE idx 2 again, then correct pin -> OK.
- VERIFY acct FFFF with no match across 10 slots -> NO_ACCT, rsp_valid at cycle 11. WRITE idx 10 -> BAD_IDX. req_op 11 -> BAD_OP.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. Assert rst mid-SEARCH of a DEBIT -> outputs at reset values, balance unchanged on a later VERIFY... except valid bits are cleared, so reload with WRITE first and then confirm the DEBIT had no effect.
